// File: rtl/bp_be_pkg.sv
// bp_be_pkg
//   Shared types and constants for the back-end LCE request concentrator.
//   - bp_be_lce_arb_state_e       : arbiter lock state
//   - bp_be_lce_arb_perf_width_gp : width of each stall counter
//   - bp_be_lce_arb_id_width()    : channel-id width, never below 1 bit
package bp_be_pkg;

  typedef enum logic [0:0] {
    e_arb_unlocked = 1'b0,
    e_arb_locked   = 1'b1
  } bp_be_lce_arb_state_e;

  localparam int bp_be_lce_arb_perf_width_gp = 32;

  function automatic int bp_be_lce_arb_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bp_be_lce_req_arb_if.sv
// bp_be_lce_req_arb_if
//   Handshake bundle between the request sources, the concentrator and the
//   outgoing LCE request link.
//   Source side : req_i, req_last_i, req_v_i  -> ; <- req_ready_o
//   Link side   : lce_req_o, lce_req_last_o, lce_req_chan_o, lce_req_v_o -> ;
//                 <- lce_req_ready_i
//   modport slave  : the concentrator
//   modport master : the environment (sources plus downstream link)
interface bp_be_lce_req_arb_if
  import bp_be_pkg::*;
#(
  parameter int num_chan_p   = 2,
  parameter int data_width_p = 128
);

  localparam int chan_id_width_lp = bp_be_lce_arb_id_width(num_chan_p);

  logic [num_chan_p-1:0][data_width_p-1:0] req_i;
  logic [num_chan_p-1:0]                   req_last_i;
  logic [num_chan_p-1:0]                   req_v_i;
  logic [num_chan_p-1:0]                   req_ready_o;

  logic [data_width_p-1:0]                 lce_req_o;
  logic                                    lce_req_last_o;
  logic [chan_id_width_lp-1:0]             lce_req_chan_o;
  logic                                    lce_req_v_o;
  logic                                    lce_req_ready_i;

  modport slave (
    input  req_i, req_last_i, req_v_i, lce_req_ready_i,
    output req_ready_o, lce_req_o, lce_req_last_o, lce_req_chan_o, lce_req_v_o
  );

  modport master (
    output req_i, req_last_i, req_v_i, lce_req_ready_i,
    input  req_ready_o, lce_req_o, lce_req_last_o, lce_req_chan_o, lce_req_v_o
  );

endinterface

// File: rtl/bp_be_lce_arb_fifo.sv
// bp_be_lce_arb_fifo
//   Per-channel beat buffer with valid/ready on the write side and
//   valid/yumi on the read side.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   data_i, v_i      : write beat and valid; accepted when ready_o is high
//   ready_o          : not full
//   data_o, v_o      : head beat, not empty
//   yumi_i           : consumer takes the head beat this cycle
//   Simultaneous push and pop leaves occupancy unchanged. Storage is not
//   reset; only pointers and the occupancy counter are.
module bp_be_lce_arb_fifo #(
  parameter int width_p = 129,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);
  localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
  localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wptr_r, rptr_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic                enq, deq;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + ptr_w_lp'(1);
  endfunction

  assign ready_o = (cnt_r != full_cnt_lp);
  assign v_o     = (cnt_r != '0);
  assign data_o  = mem_r[rptr_r];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (enq) wptr_r <= ptr_inc(wptr_r);
      if (deq) rptr_r <= ptr_inc(rptr_r);
      case ({enq, deq})
        2'b10:   cnt_r <= cnt_r + cnt_w_lp'(1);
        2'b01:   cnt_r <= cnt_r - cnt_w_lp'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/bp_be_lce_req_arb.sv
// bp_be_lce_req_arb
//   N-channel LCE request concentrator. Each source has its own buffer; the
//   single outgoing link is shared round-robin, and a multi-beat packet keeps
//   the link locked to its channel until its last beat leaves.
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   io (slave)       : per-channel request inputs with ready, plus the
//                      granted beat/last/channel/valid and downstream ready
//   stall_cnt_o      : per-channel stall counters, present only when
//                      BP_BE_LCE_ARB_PERF_EN is defined
//   Optional feature macro: BP_BE_LCE_ARB_PERF_EN
module bp_be_lce_req_arb
  import bp_be_pkg::*;
#(
  parameter int num_chan_p   = 2,
  parameter int data_width_p = 128,
  parameter int buf_els_p    = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bp_be_lce_req_arb_if.slave io
`ifdef BP_BE_LCE_ARB_PERF_EN
  ,
  output logic [num_chan_p-1:0][bp_be_lce_arb_perf_width_gp-1:0] stall_cnt_o
`endif
);

  localparam int chan_id_width_lp = bp_be_lce_arb_id_width(num_chan_p);

  typedef logic [chan_id_width_lp-1:0] chan_id_t;

  logic [num_chan_p-1:0] fifo_v;
  logic [num_chan_p-1:0] fifo_ready;
  logic [num_chan_p-1:0] yumi;
  logic [data_width_p:0] fifo_data [num_chan_p];

  bp_be_lce_arb_state_e state_r, state_n;
  chan_id_t             lock_chan_r, lock_chan_n;
  chan_id_t             rr_ptr_r, rr_ptr_n;
  chan_id_t             grant_id;
  logic                 grant_v;
  logic                 out_last;
  logic                 hs;

  // Cyclic channel addition: (base + off) mod num_chan_p, off < num_chan_p.
  function automatic chan_id_t chan_add(input chan_id_t base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= num_chan_p) s = s - num_chan_p;
    return chan_id_t'(s);
  endfunction

  // ---- stage: per-channel input buffers ----
  for (genvar c = 0; c < num_chan_p; c++) begin : g_chan
    bp_be_lce_arb_fifo #(
      .width_p(data_width_p + 1),
      .els_p  (buf_els_p)
    ) fifo (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .data_i   ({io.req_last_i[c], io.req_i[c]}),
      .v_i      (io.req_v_i[c]),
      .ready_o  (fifo_ready[c]),
      .data_o   (fifo_data[c]),
      .v_o      (fifo_v[c]),
      .yumi_i   (yumi[c])
    );
  end

  assign io.req_ready_o = fifo_ready;

  // ---- stage: grant selection (combinational from buffer heads) ----
  // While locked, no other channel may be granted even when the locked
  // channel is momentarily empty, so the packet is never interleaved.
  always_comb begin
    grant_id = lock_chan_r;
    grant_v  = 1'b0;
    if (state_r == e_arb_locked) begin
      grant_v = fifo_v[lock_chan_r];
    end else begin
      for (int i = 0; i < num_chan_p; i++) begin
        if (!grant_v && fifo_v[chan_add(rr_ptr_r, i)]) begin
          grant_v  = 1'b1;
          grant_id = chan_add(rr_ptr_r, i);
        end
      end
    end
  end

  assign out_last          = fifo_data[grant_id][data_width_p];
  assign io.lce_req_o      = fifo_data[grant_id][data_width_p-1:0];
  assign io.lce_req_last_o = out_last;
  assign io.lce_req_chan_o = grant_id;
  assign io.lce_req_v_o    = grant_v;
  assign hs                = grant_v & io.lce_req_ready_i;

  always_comb begin
    yumi = '0;
    for (int c = 0; c < num_chan_p; c++) begin
      yumi[c] = hs && (grant_id == chan_id_t'(c));
    end
  end

  // ---- stage: lock FSM and round-robin pointer ----
  always_comb begin
    state_n     = state_r;
    lock_chan_n = lock_chan_r;
    rr_ptr_n    = rr_ptr_r;
    if (hs) begin
      if (out_last) begin
        state_n  = e_arb_unlocked;
        rr_ptr_n = chan_add(grant_id, 1);
      end else begin
        state_n     = e_arb_locked;
        lock_chan_n = grant_id;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_arb_unlocked;
      lock_chan_r <= '0;
      rr_ptr_r    <= '0;
    end else begin
      state_r     <= state_n;
      lock_chan_r <= lock_chan_n;
      rr_ptr_r    <= rr_ptr_n;
    end
  end

`ifdef BP_BE_LCE_ARB_PERF_EN
  // ---- stage: stall counters ----
  // A channel stalls when it holds data but is not the one leaving this cycle.
  logic [num_chan_p-1:0][bp_be_lce_arb_perf_width_gp-1:0] stall_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_r <= '0;
    end else begin
      for (int c = 0; c < num_chan_p; c++) begin
        if (fifo_v[c] && !yumi[c] && (stall_cnt_r[c] != '1)) begin
          stall_cnt_r[c] <= stall_cnt_r[c] + bp_be_lce_arb_perf_width_gp'(1);
        end
      end
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_bp_be_lce_req_arb.sv
// tb_bp_be_lce_req_arb
//   Directed bench for the two-channel, depth-2 concentrator. Inputs are
//   driven and outputs sampled 1 time unit after each rising edge.
module tb_bp_be_lce_req_arb;
  import bp_be_pkg::*;

  localparam int N = 2;
  localparam int W = 128;
  localparam int E = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bp_be_lce_req_arb_if #(.num_chan_p(N), .data_width_p(W)) bus ();

`ifdef BP_BE_LCE_ARB_PERF_EN
  logic [N-1:0][31:0] stall_cnt;
`endif

  bp_be_lce_req_arb #(
    .num_chan_p  (N),
    .data_width_p(W),
    .buf_els_p   (E)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .io       (bus.slave)
`ifdef BP_BE_LCE_ARB_PERF_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  // Stall-and-lock scenario: expected output per step.
  int t3_v [9] = '{0, 1, 1, 0, 0, 1, 1, 1, 1};
  int t3_ch[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
  int t3_d [9] = '{0, 'h40, 'h41, 0, 0, 'h42, 'h30, 'h31, 'h32};
  int t3_l [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
  // Downstream backpressure scenario.
  int t4_v [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int t4_d [9] = '{0, 'h50, 'h50, 'h50, 'h50, 'h50, 'h51, 'h52, 0};
  int t4_r [9] = '{1, 1, 0, 0, 0, 0, 1, 1, 1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int c, input logic v, input logic [W-1:0] d, input logic last);
    bus.req_v_i[c]    = v;
    bus.req_i[c]      = d;
    bus.req_last_i[c] = last;
  endtask

  task automatic do_reset();
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    bus.lce_req_ready_i = 1'b1;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int k0, k1, e0, e1, nout, exp_chan;
    logic acc0, acc1;

    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    bus.lce_req_ready_i = 1'b1;

    // Reset state.
    tick();
    check("rst_ready", bus.req_ready_o, 2'b11);
    check("rst_v", bus.lce_req_v_o, 1'b0);
    reset_n = 1'b1;
    tick();

    // Single beat on ch0: not visible in its acceptance cycle, visible next.
    drive(0, 1'b1, 'hA5, 1'b1);
    check("t1_nobypass", bus.lce_req_v_o, 1'b0);
    tick();
    drive(0, 1'b0, '0, 1'b0);
    check("t1_v", bus.lce_req_v_o, 1'b1);
    check("t1_data", bus.lce_req_o, 'hA5);
    check("t1_chan", bus.lce_req_chan_o, 0);
    check("t1_last", bus.lce_req_last_o, 1'b1);
    tick();
    check("t1_drained", bus.lce_req_v_o, 1'b0);

    // Both channels streaming single-beat packets; pointer now at ch1.
    k0 = 0; k1 = 0; e0 = 0; e1 = 0; nout = 0; exp_chan = 1;
    drive(0, 1'b1, 'h10, 1'b1);
    drive(1, 1'b1, 'h20, 1'b1);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (bus.lce_req_v_o) begin
        check("rr_chan", bus.lce_req_chan_o, exp_chan);
        if (bus.lce_req_chan_o == 1'b0) begin
          check("rr_data0", bus.lce_req_o, W'('h10 + e0));
          e0++;
        end else begin
          check("rr_data1", bus.lce_req_o, W'('h20 + e1));
          e1++;
        end
        exp_chan = 1 - exp_chan;
        nout++;
      end
      acc0 = bus.req_v_i[0] & bus.req_ready_o[0];
      acc1 = bus.req_v_i[1] & bus.req_ready_o[1];
      tick();
      if (acc0) begin k0++; bus.req_i[0] = W'('h10 + k0); end
      if (acc1) begin k1++; bus.req_i[1] = W'('h20 + k1); end
    end
    check("rr_count", nout, 11);

    // Locked 3-beat packet on ch0 with a 2-cycle source gap; ch1 waits.
    do_reset();
    k1 = 0;
    drive(1, 1'b1, 'h30, 1'b1);
    for (int s = 0; s < 9; s++) begin
      check("lock_v", bus.lce_req_v_o, t3_v[s][0]);
      if (t3_v[s] != 0) begin
        check("lock_chan", bus.lce_req_chan_o, t3_ch[s]);
        check("lock_data", bus.lce_req_o, W'(t3_d[s]));
        check("lock_last", bus.lce_req_last_o, t3_l[s][0]);
      end
      if (s == 2) check("lock_ch1_full", bus.req_ready_o[1], 1'b0);
      case (s)
        0:       drive(0, 1'b1, 'h40, 1'b0);
        1:       drive(0, 1'b1, 'h41, 1'b0);
        4:       drive(0, 1'b1, 'h42, 1'b1);
        default: drive(0, 1'b0, '0, 1'b0);
      endcase
      acc1 = bus.req_v_i[1] & bus.req_ready_o[1];
      tick();
      if (acc1) begin k1++; bus.req_i[1] = W'('h30 + k1); end
    end

    // Downstream not ready for 5 cycles while ch1 keeps offering beats.
    do_reset();
    k1 = 0;
    bus.lce_req_ready_i = 1'b0;
    for (int s = 0; s < 9; s++) begin
      if (s == 5) bus.lce_req_ready_i = 1'b1;
      check("bp_v", bus.lce_req_v_o, t4_v[s][0]);
      if (t4_v[s] != 0) begin
        check("bp_chan", bus.lce_req_chan_o, 1);
        check("bp_data", bus.lce_req_o, W'(t4_d[s]));
      end
      check("bp_ready1", bus.req_ready_o[1], t4_r[s][0]);
      check("bp_ready0", bus.req_ready_o[0], 1'b1);
      if (s <= 6) drive(1, 1'b1, W'('h50 + k1), 1'b1);
      else        drive(1, 1'b0, '0, 1'b0);
      acc1 = bus.req_v_i[1] & bus.req_ready_o[1];
      tick();
      if (acc1) k1++;
    end

    // Reset while locked mid-packet discards buffers and lock.
    do_reset();
    drive(0, 1'b1, 'h60, 1'b0);
    drive(1, 1'b1, 'h70, 1'b1);
    tick();
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    check("mr_v", bus.lce_req_v_o, 1'b1);
    check("mr_chan", bus.lce_req_chan_o, 0);
    check("mr_data", bus.lce_req_o, 'h60);
    tick();
    check("mr_lock_stall", bus.lce_req_v_o, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mr_rst_v", bus.lce_req_v_o, 1'b0);
    check("mr_rst_ready", bus.req_ready_o, 2'b11);
    tick();
    reset_n = 1'b1;
    check("mr_empty", bus.lce_req_v_o, 1'b0);
    drive(1, 1'b1, 'h71, 1'b1);
    tick();
    drive(1, 1'b0, '0, 1'b0);
    check("mr_post_v", bus.lce_req_v_o, 1'b1);
    check("mr_post_chan", bus.lce_req_chan_o, 1);
    check("mr_post_data", bus.lce_req_o, 'h71);
    tick();
    check("mr_post_drain", bus.lce_req_v_o, 1'b0);

`ifdef BP_BE_LCE_ARB_PERF_EN
    // ch1 beat held back by a locked ch0 packet for 4 cycles.
    do_reset();
    check("pf_rst", stall_cnt[1], 0);
    drive(0, 1'b1, 'h80, 1'b0);
    drive(1, 1'b1, 'h90, 1'b1);
    tick();
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    check("pf_b0", bus.lce_req_o, 'h80);
    tick();
    check("pf_gap", bus.lce_req_v_o, 1'b0);
    tick();
    drive(0, 1'b1, 'h81, 1'b1);
    tick();
    drive(0, 1'b0, '0, 1'b0);
    check("pf_b1_last", bus.lce_req_last_o, 1'b1);
    check("pf_b1", bus.lce_req_o, 'h81);
    tick();
    check("pf_ch1", bus.lce_req_chan_o, 1);
    check("pf_cnt1", stall_cnt[1], 4);
    tick();
    check("pf_cnt1_hold", stall_cnt[1], 4);
    check("pf_cnt0", stall_cnt[0], 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
